// File: rtl/udp_reg_readback.sv
// udp_reg_readback: snapshots the register file on each write-complete pulse and streams it as one UDP payload frame
module udp_reg_readback #(
   parameter int Nregs = 16,
   parameter logic [15:0] MAGIC = 16'hA55A
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dv_in,
   input  logic [Nregs-1:0][31:0] wr_val,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [7:0]             m_tdata,
   output logic                   m_tlast,
   output logic                   m_tuser,
   output logic                   busy,
   output logic [15:0]            seq_out,
   output logic [7:0]             drop_cnt
);
   localparam logic [15:0] LAST = 16'(8 + 4 * Nregs - 1);
   localparam logic [15:0] NREGS16 = 16'(Nregs);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
   state_t state, state_n;
   logic [15:0] cnt, cnt_n, seq_n;
   logic [Nregs-1:0][31:0] snap, snap_n;
   logic pend, pend_n, fire, done, start, last_n;
   logic [7:0] drop_n, hdr_b, dat_b, data_n;
   logic [31:0] word;
   assign m_tuser = 1'b0;
   // next state, request bookkeeping and the byte to present after the edge; the snapshot shifts down one
   // register per four data bytes so the current register always sits in snap[0]
   always_comb begin
      fire = m_tvalid & m_tready;
      done = fire & m_tlast;
      state_n = state;
      cnt_n = cnt;
      snap_n = snap;
      seq_n = seq_out;
      pend_n = pend;
      drop_n = drop_cnt;
      start = 1'b0;
      if (state == IDLE) start = dv_in;
      else begin
         if (dv_in & pend & !done) drop_n = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
         if (dv_in) pend_n = 1'b1;
         if (fire) begin
            cnt_n = cnt + 16'd1;
            if (state == HDR && cnt == 16'd7) state_n = DATA;
            if (state == DATA && cnt[1:0] == 2'd3) snap_n = snap >> 32;
            if (m_tlast) begin
               seq_n = seq_out + 16'd1;
               start = pend | dv_in;
               pend_n = pend & dv_in;
               state_n = IDLE;
            end
         end
      end
      if (start) begin
         state_n = HDR;
         cnt_n = 16'd0;
         snap_n = wr_val;
      end
      word = snap_n[0];
      hdr_b = cnt_n[2:0] == 3'd0 ? MAGIC[15:8] :
              cnt_n[2:0] == 3'd1 ? MAGIC[7:0] :
              cnt_n[2:0] == 3'd2 ? seq_n[15:8] :
              cnt_n[2:0] == 3'd3 ? seq_n[7:0] :
              cnt_n[2:0] == 3'd4 ? NREGS16[15:8] :
              cnt_n[2:0] == 3'd5 ? NREGS16[7:0] : 8'd0;
      dat_b = cnt_n[1:0] == 2'd0 ? word[31:24] :
              cnt_n[1:0] == 2'd1 ? word[23:16] :
              cnt_n[1:0] == 2'd2 ? word[15:8] : word[7:0];
      data_n = state_n == IDLE ? 8'd0 : cnt_n < 16'd8 ? hdr_b : dat_b;
      last_n = state_n == DATA && cnt_n == LAST;
   end
   // state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= 16'd0;
         snap <= '0;
         pend <= 1'b0;
         seq_out <= 16'd0;
         drop_cnt <= 8'd0;
         m_tvalid <= 1'b0;
         m_tdata <= 8'd0;
         m_tlast <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         snap <= snap_n;
         pend <= pend_n;
         seq_out <= seq_n;
         drop_cnt <= drop_n;
         m_tvalid <= state_n != IDLE;
         m_tdata <= data_n;
         m_tlast <= last_n;
         busy <= state_n != IDLE;
      end
   end
endmodule
